// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port read/write arbiters.
package mem_arb_pkg;

    // Outstanding-count width: holds 0..16.
    localparam int MAX_OUTS_W = 5;

    // AXI widths of the memory port. The AR payload struct is sized by these,
    // so arbiter ADDR_W/ID_W parameters must agree with them.
    localparam int AR_ADDR_W = 32;
    localparam int AR_ID_W   = 1;

    typedef struct packed {
        logic [AR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [AR_ID_W-1:0]   id;
    } ar_payload_t;

    typedef enum logic {
        AR_IDLE,
        AR_HOLD
    } ar_state_t;

    // Index width for n requesters, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Upstream (per-master) and downstream AXI4 read channels of mem_rd_arbiter.
// slave  : the arbiter's view.
// master : the surrounding masters/memory (or a bench) driving the arbiter.
interface mem_rd_arbiter_if #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 1
);
    import mem_arb_pkg::*;

    localparam int IDX_W = idx_w(NUM_M);

    // Upstream AR, packed per master
    logic [NUM_M-1:0]        s_arvalid;
    logic [NUM_M-1:0]        s_arready;
    logic [NUM_M*ADDR_W-1:0] s_araddr;
    logic [NUM_M*ID_W-1:0]   s_arid;
    logic [NUM_M*8-1:0]      s_arlen;
    logic [NUM_M*3-1:0]      s_arsize;
    logic [NUM_M*2-1:0]      s_arburst;
    logic [NUM_M*4-1:0]      s_arcache;
    logic [NUM_M*3-1:0]      s_arprot;

    // Upstream R, shared payload qualified per master
    logic [NUM_M-1:0]        s_rvalid;
    logic [NUM_M-1:0]        s_rready;
    logic [DATA_W-1:0]       s_rdata;
    logic [ID_W-1:0]         s_rid;
    logic [1:0]              s_rresp;
    logic                    s_rlast;

    // Downstream AR
    logic                    m_arvalid;
    logic                    m_arready;
    logic [ADDR_W-1:0]       m_araddr;
    logic [7:0]              m_arlen;
    logic [2:0]              m_arsize;
    logic [1:0]              m_arburst;
    logic [3:0]              m_arcache;
    logic [2:0]              m_arprot;
    logic [IDX_W+ID_W-1:0]   m_arid;

    // Downstream R
    logic                    m_rvalid;
    logic                    m_rready;
    logic [DATA_W-1:0]       m_rdata;
    logic [IDX_W+ID_W-1:0]   m_rid;
    logic [1:0]              m_rresp;
    logic                    m_rlast;

    // Status
    logic [NUM_M*MAX_OUTS_W-1:0] outs_cnt;
    logic                        rsp_err;

    modport slave (
        input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_arcache, s_arprot,
        output s_arready,
        output s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
        input  s_rready,
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arcache, m_arprot, m_arid,
        input  m_arready,
        input  m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
        output m_rready,
        output outs_cnt, rsp_err
    );

    modport master (
        output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_arcache, s_arprot,
        input  s_arready,
        input  s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
        output s_rready,
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arcache, m_arprot, m_arid,
        output m_arready,
        output m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
        input  m_rready,
        input  outs_cnt, rsp_err
    );

endinterface

// File: rtl/mem_rd_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr (wrapping), one-hot
// grant plus binary index. Shared by the AR and AW arbiters.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int IDX_W = idx_w(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_M-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan NUM_M slots starting at ptr; ptr values >= NUM_M wrap.
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            c = (int'(ptr) + k) % NUM_M;
            if (!any && req[c]) begin
                any      = 1'b1;
                idx      = IDX_W'(c);
                grant[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one AXI4 read path between NUM_M masters.
// AR is arbitrated round-robin and registered (one AR per two cycles); the
// winning index is prepended to ARID, and R beats are routed back by it
// combinationally. Per-master outstanding bursts are capped at MAX_OUTS.
// Optional: MEM_RD_ARB_PRIO_EN gives master 0 strict priority, round-robin
// among the rest.
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_M    = 2,
    parameter int ADDR_W   = AR_ADDR_W,
    parameter int DATA_W   = 64,
    parameter int ID_W     = AR_ID_W,
    parameter int MAX_OUTS = 8
) (
    input logic             uncoreclk,
    input logic             uncorersts,
    mem_rd_arbiter_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_M);
    localparam logic [MAX_OUTS_W-1:0] CNT_MAX = MAX_OUTS_W'(MAX_OUTS);

    ar_state_t   state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt, grant_idx_q;
    logic [NUM_M-1:0] eligible, pick_req, pick_grant, grant, ar_ready;
    logic [IDX_W-1:0] pick_idx, grant_idx;
    logic             pick_any, grant_any, load;
    ar_payload_t      pay_sel, pay_q;

    logic [NUM_M-1:0][MAX_OUTS_W-1:0] cnt;
    logic [NUM_M-1:0] ar_inc, r_dec, s_rvalid;
    logic [IDX_W-1:0] r_idx;
    logic             r_idx_ok, r_cnt_zero, m_rready, r_hs, r_last_hs, rsp_err;

    // Pointer after serving g; in priority mode master 0 never owns the ring.
    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
        int n;
        n = (int'(g) + 1) % NUM_M;
`ifdef MEM_RD_ARB_PRIO_EN
        if (n == 0) n = 1;
`endif
        return IDX_W'(n);
    endfunction

    rr_picker #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_picker (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef MEM_RD_ARB_PRIO_EN
    assign pick_req = eligible & {{(NUM_M-1){1'b1}}, 1'b0};

    // Master 0 pre-empts the ring whenever it is eligible.
    always_comb begin
        grant     = pick_grant;
        grant_idx = pick_idx;
        grant_any = pick_any;
        if (eligible[0]) begin
            grant     = {{(NUM_M-1){1'b0}}, 1'b1};
            grant_idx = '0;
            grant_any = 1'b1;
        end
    end
`else
    assign pick_req  = eligible;
    assign grant     = pick_grant;
    assign grant_idx = pick_idx;
    assign grant_any = pick_any;
`endif

    // Mux the winning master's AR payload into the capture register input.
    always_comb begin
        pay_sel = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant[i]) begin
                pay_sel.addr  = bus.s_araddr[i*ADDR_W +: ADDR_W];
                pay_sel.len   = bus.s_arlen[i*8 +: 8];
                pay_sel.size  = bus.s_arsize[i*3 +: 3];
                pay_sel.burst = bus.s_arburst[i*2 +: 2];
                pay_sel.cache = bus.s_arcache[i*4 +: 4];
                pay_sel.prot  = bus.s_arprot[i*3 +: 3];
                pay_sel.id    = bus.s_arid[i*ID_W +: ID_W];
            end
        end
    end

    // AR FSM next state: accept upstream in IDLE, hold downstream until taken.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        ar_ready   = '0;
        load       = 1'b0;
        case (state)
            AR_IDLE: begin
                if (grant_any) begin
                    ar_ready  = grant;
                    load      = 1'b1;
                    state_nxt = AR_HOLD;
                end
            end
            AR_HOLD: begin
                if (bus.m_arready) begin
                    state_nxt  = AR_IDLE;
                    rr_ptr_nxt = ptr_after(grant_idx_q);
                end
            end
            default: state_nxt = AR_IDLE;
        endcase
    end

    // AR FSM state, ring pointer and captured payload.
    always_ff @(posedge uncoreclk or posedge uncorersts) begin
        if (uncorersts) begin
            state       <= AR_IDLE;
            rr_ptr      <= '0;
            grant_idx_q <= '0;
            pay_q       <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (load) begin
                grant_idx_q <= grant_idx;
                pay_q       <= pay_sel;
            end
        end
    end

    assign bus.s_arready = ar_ready;
    assign bus.m_arvalid = (state == AR_HOLD);
    assign bus.m_araddr  = pay_q.addr;
    assign bus.m_arlen   = pay_q.len;
    assign bus.m_arsize  = pay_q.size;
    assign bus.m_arburst = pay_q.burst;
    assign bus.m_arcache = pay_q.cache;
    assign bus.m_arprot  = pay_q.prot;
    assign bus.m_arid    = {grant_idx_q, pay_q.id};

    assign r_idx    = bus.m_rid[IDX_W+ID_W-1 -: IDX_W];
    assign r_idx_ok = (int'(r_idx) < NUM_M);

    // R routing by ARID prefix; unknown index is drained (ready forced high).
    always_comb begin
        s_rvalid   = '0;
        m_rready   = 1'b1;
        r_cnt_zero = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_idx == IDX_W'(i)) begin
                s_rvalid[i] = bus.m_rvalid;
                m_rready    = bus.s_rready[i];
                r_cnt_zero  = (cnt[i] == '0);
            end
        end
    end

    assign r_hs      = bus.m_rvalid & m_rready;
    assign r_last_hs = r_hs & bus.m_rlast;

    assign bus.s_rvalid = s_rvalid;
    assign bus.m_rready = m_rready;
    assign bus.s_rdata  = bus.m_rdata;
    assign bus.s_rid    = bus.m_rid[ID_W-1:0];
    assign bus.s_rresp  = bus.m_rresp;
    assign bus.s_rlast  = bus.m_rlast;

    for (genvar g = 0; g < NUM_M; g++) begin : g_outs
        logic [MAX_OUTS_W-1:0] cnt_q;

        assign eligible[g] = bus.s_arvalid[g] & (cnt_q != CNT_MAX);
        assign ar_inc[g]   = bus.s_arvalid[g] & ar_ready[g];
        assign r_dec[g]    = r_last_hs & (r_idx == IDX_W'(g));
        assign cnt[g]      = cnt_q;

        // Outstanding bursts: accept in, rlast out; a stray rlast at zero is held.
        always_ff @(posedge uncoreclk or posedge uncorersts) begin
            if (uncorersts)
                cnt_q <= '0;
            else if (ar_inc[g] && !r_dec[g])
                cnt_q <= cnt_q + MAX_OUTS_W'(1);
            else if (r_dec[g] && !ar_inc[g] && cnt_q != '0)
                cnt_q <= cnt_q - MAX_OUTS_W'(1);
        end
    end

    assign bus.outs_cnt = cnt;

    // Sticky error on any beat to an idle master or a nonexistent index.
    always_ff @(posedge uncoreclk or posedge uncorersts) begin
        if (uncorersts)
            rsp_err <= 1'b0;
        else if (r_hs && (!r_idx_ok || r_cnt_zero))
            rsp_err <= 1'b1;
    end

    assign bus.rsp_err = rsp_err;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboard bench for mem_rd_arbiter: stimulus pushes expected AR/R
// transfers into queues, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_rd_arbiter;
    import mem_arb_pkg::*;

    localparam int NUM_M = 2, ADDR_W = 32, DATA_W = 64, ID_W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    mem_rd_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTS(8)) dut (
        .uncoreclk  (clk),
        .uncorersts (rst),
        .bus        (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  arid;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        logic [1:0]  rvalid;
        logic        rready;
        logic [63:0] data;
        logic        id;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [1:0] id, input logic [7:0] len);
        ar_exp_t e;
        e.addr = a; e.arid = id; e.len = len;
        ar_q.push_back(e);
    endtask

    task automatic push_r(input logic [1:0] v, input logic rdy, input logic [63:0] d,
                          input logic id, input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.rvalid = v; e.rready = rdy; e.data = d; e.id = id; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endtask

    // Monitor: compare every downstream AR handshake and every R beat presented.
    always @(negedge clk) begin
        ar_exp_t ae;
        r_exp_t  re;
        if (!rst) begin
            if (bus.m_arvalid && bus.m_arready) begin
                if (ar_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ar_unexpected: got addr 0x%0h, expected no AR", bus.m_araddr);
                end else begin
                    ae = ar_q.pop_front();
                    chk("ar_addr", bus.m_araddr, ae.addr);
                    chk("ar_id", bus.m_arid, ae.arid);
                    chk("ar_len", bus.m_arlen, ae.len);
                end
            end
            if (bus.m_rvalid) begin
                if (r_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL r_unexpected: got s_rvalid 0x%0h, expected no beat", bus.s_rvalid);
                end else begin
                    re = r_q.pop_front();
                    chk("r_svalid", bus.s_rvalid, re.rvalid);
                    chk("r_mready", bus.m_rready, re.rready);
                    chk("r_data", bus.s_rdata, re.data);
                    chk("r_id", bus.s_rid, re.id);
                    chk("r_resp", bus.s_rresp, re.resp);
                    chk("r_last", bus.s_rlast, re.last);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise AR for master m, wait (bounded) for its accept, then drop it.
    task automatic issue(input int m, input logic [31:0] a, input logic id, input logic [7:0] len);
        int t;
        bus.s_araddr[m*ADDR_W +: ADDR_W] = a;
        bus.s_arid[m]          = id;
        bus.s_arlen[m*8 +: 8]  = len;
        bus.s_arvalid[m]       = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.s_arready[m] && t < 200);
        chk("issue_accept", bus.s_arready[m], 1'b1);
        @(posedge clk);
        #1;
        bus.s_arvalid[m] = 1'b0;
    endtask

    task automatic do_reset();
        chk("ar_q_drained", ar_q.size(), 0);
        chk("r_q_drained", r_q.size(), 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_arvalid", bus.m_arvalid, 1'b0);
        chk("rst_outs", bus.outs_cnt, 0);
        chk("rst_err", bus.rsp_err, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_arid = '0; bus.s_arlen = '0;
        bus.s_arsize = '0; bus.s_arburst = '0; bus.s_arcache = '0; bus.s_arprot = '0;
        bus.s_rready = '0; bus.m_arready = 1'b0;
        bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rid = '0; bus.m_rresp = '0; bus.m_rlast = 1'b0;

        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_arvalid", bus.m_arvalid, 1'b0);
        chk("rst_arready", bus.s_arready, 2'b00);
        chk("rst_outs", bus.outs_cnt, 0);
        chk("rst_err", bus.rsp_err, 1'b0);
        @(posedge clk);
        #1;

        // 1: both masters continuously requesting
        bus.m_arready = 1'b1;
`ifdef MEM_RD_ARB_PRIO_EN
        push_ar(32'h1000, 2'b01, 8'd1); push_ar(32'h1100, 2'b01, 8'd2);
        push_ar(32'h2000, 2'b10, 8'd3); push_ar(32'h2100, 2'b10, 8'd4);
`else
        push_ar(32'h1000, 2'b01, 8'd1); push_ar(32'h2000, 2'b10, 8'd3);
        push_ar(32'h1100, 2'b01, 8'd2); push_ar(32'h2100, 2'b10, 8'd4);
`endif
        fork
            begin issue(0, 32'h1000, 1'b1, 8'd1); issue(0, 32'h1100, 1'b1, 8'd2); end
            begin issue(1, 32'h2000, 1'b0, 8'd3); issue(1, 32'h2100, 1'b0, 8'd4); end
        join
        idle(3);
        chk("t1_outs", bus.outs_cnt, {5'd2, 5'd2});

        // 2: downstream stall in HOLD
        bus.m_arready = 1'b0;
        push_ar(32'h3000, 2'b01, 8'd7);
        push_ar(32'h4000, 2'b10, 8'd8);
        fork
            issue(0, 32'h3000, 1'b1, 8'd7);
            issue(1, 32'h4000, 1'b0, 8'd8);
            begin
                int t;
                t = 0;
                do begin @(negedge clk); t++; end while (!bus.m_arvalid && t < 50);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("hold_valid", bus.m_arvalid, 1'b1);
                    chk("hold_addr", bus.m_araddr, 32'h3000);
                    chk("hold_id", bus.m_arid, 2'b01);
                    chk("hold_no_ready", bus.s_arready, 2'b00);
                end
                @(posedge clk);
                #1;
                bus.m_arready = 1'b1;
            end
        join
        idle(3);
        do_reset();

        // 3: m1 fills its outstanding limit, gets masked, then released by rlast
        for (int i = 0; i < 8; i++) begin
            push_ar(32'h5000 + 32'(i * 16), 2'b10, 8'(i));
            issue(1, 32'h5000 + 32'(i * 16), 1'b0, 8'(i));
        end
        idle(2);
        chk("t3_full", bus.outs_cnt[9:5], 5'd8);
        bus.s_araddr[ADDR_W +: ADDR_W] = 32'h5800;
        bus.s_arid[1]     = 1'b0;
        bus.s_arlen[15:8] = 8'd9;
        bus.s_arvalid[1]  = 1'b1;
        push_ar(32'h6000, 2'b01, 8'h20);
        issue(0, 32'h6000, 1'b1, 8'h20);
        repeat (3) begin
            @(negedge clk);
            chk("t3_masked", bus.s_arready[1], 1'b0);
        end
        @(posedge clk);
        #1;
        bus.m_rvalid = 1'b1; bus.m_rid = 2'b10; bus.m_rlast = 1'b1;
        bus.m_rdata = 64'hDEAD_BEEF_0000_0001; bus.m_rresp = 2'b00; bus.s_rready = 2'b10;
        push_r(2'b10, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 2'b00, 1'b1);
        push_ar(32'h5800, 2'b10, 8'd9);
        @(posedge clk);
        #1;
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        @(negedge clk);
        chk("t3_regrant", bus.s_arready[1], 1'b1);
        @(posedge clk);
        #1;
        bus.s_arvalid[1] = 1'b0;
        idle(3);
        chk("t3_outs", bus.outs_cnt, {5'd8, 5'd1});

        // 4: m0 accept and m0 rlast in the same cycle
        bus.s_araddr[0 +: ADDR_W] = 32'h7000; bus.s_arid[0] = 1'b1;
        bus.s_arlen[7:0] = 8'h11; bus.s_arvalid[0] = 1'b1;
        bus.m_rvalid = 1'b1; bus.m_rid = 2'b01; bus.m_rlast = 1'b1;
        bus.m_rdata = 64'h0123_4567_89AB_CDEF; bus.m_rresp = 2'b10; bus.s_rready = 2'b01;
        push_r(2'b01, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 2'b10, 1'b1);
        push_ar(32'h7000, 2'b01, 8'h11);
        @(negedge clk);
        chk("t4_accept", bus.s_arready, 2'b01);
        @(posedge clk);
        #1;
        bus.s_arvalid[0] = 1'b0; bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        @(negedge clk);
        chk("t4_cnt0_same", bus.outs_cnt[4:0], 5'd1);
        idle(3);
        do_reset();

        // 5: stray beat to idle m1, then stall by s_rready[1]
        bus.m_rvalid = 1'b1; bus.m_rid = 2'b11; bus.m_rlast = 1'b1;
        bus.m_rdata = 64'h5555_AAAA_5555_AAAA; bus.m_rresp = 2'b00; bus.s_rready = 2'b10;
        push_r(2'b10, 1'b1, 64'h5555_AAAA_5555_AAAA, 1'b1, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        bus.s_rready = 2'b01; bus.m_rlast = 1'b0;
        push_r(2'b10, 1'b0, 64'h5555_AAAA_5555_AAAA, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        chk("t5_err_set", bus.rsp_err, 1'b1);
        chk("t5_cnt_held", bus.outs_cnt, 0);
        @(posedge clk);
        #1;
        bus.m_rvalid = 1'b0;
        idle(3);
        chk("t5_err_sticky", bus.rsp_err, 1'b1);
        do_reset();

        // 6: m0 keeps requesting three times, m1 once
`ifdef MEM_RD_ARB_PRIO_EN
        push_ar(32'h8000, 2'b01, 8'd0); push_ar(32'h8100, 2'b01, 8'd1);
        push_ar(32'h8200, 2'b01, 8'd2); push_ar(32'h9000, 2'b10, 8'd3);
`else
        push_ar(32'h8000, 2'b01, 8'd0); push_ar(32'h9000, 2'b10, 8'd3);
        push_ar(32'h8100, 2'b01, 8'd1); push_ar(32'h8200, 2'b01, 8'd2);
`endif
        fork
            begin
                issue(0, 32'h8000, 1'b1, 8'd0);
                issue(0, 32'h8100, 1'b1, 8'd1);
                issue(0, 32'h8200, 1'b1, 8'd2);
            end
            issue(1, 32'h9000, 1'b0, 8'd3);
        join
        idle(4);
        chk("t6_outs", bus.outs_cnt, {5'd1, 5'd3});

        chk("ar_q_drained", ar_q.size(), 0);
        chk("r_q_drained", r_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
